// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 asynchronous serial receiver, LSB first.
// Turns the raw RX pin into one-cycle byte strobes for the command parser
// and flags framing errors.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   uart_din   raw serial line, idle high, asynchronous to clk
//   din_vld    one-cycle strobe: din_data holds a newly received byte
//   din_data   last correctly framed byte
//   frame_err  one-cycle strobe: stop bit sampled low
//   busy       high whenever the receiver is not idle
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_din,
    output logic       din_vld,
    output logic [7:0] din_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);

    // Mid-bit sampling needs a meaningful half-bit count.
    if (CLKS_PER_BIT < 4) begin : g_cfg_err
        $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             din_vld_q, din_vld_d;
    logic [7:0]       din_data_q, din_data_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             rx_s;

    assign rx_s      = sync2_q;
    assign din_vld   = din_vld_q;
    assign din_data  = din_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

    // State and datapath registers; sync flops reset to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            din_vld_q   <= 1'b0;
            din_data_q  <= 8'h00;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            din_vld_q   <= din_vld_d;
            din_data_q  <= din_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, counters, shift register and strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        sync1_d     = uart_din;
        sync2_d     = sync1_q;
        din_vld_d   = 1'b0;
        din_data_d  = din_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: glitch, not a start.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit lets a start edge right after the stop bit be caught.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        din_vld_d  = 1'b1;
                        din_data_d = shift_q;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CLKS_PER_BIT = 16.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_din = 1'b1;
    logic       din_vld;
    logic [7:0] din_data;
    logic       frame_err;
    logic       busy;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    int unsigned cycle      = 0;
    int unsigned vld_cnt    = 0;
    int unsigned ferr_cnt   = 0;
    int unsigned wide_cnt   = 0;
    int unsigned both_cnt   = 0;
    int unsigned busy_cnt   = 0;
    int unsigned vld_cycle  = 0;
    int unsigned start_cyc  = 0;
    logic        prev_vld   = 1'b0;
    logic        prev_ferr  = 1'b0;
    logic [7:0]  vld_log[$];

    uart_byte_rx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_din (uart_din),
        .din_vld  (din_vld),
        .din_data (din_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Strobe bookkeeping, sampled on the inactive edge.
    always @(negedge clk) begin
        if (din_vld) begin
            if (!prev_vld) begin
                vld_cnt++;
                vld_cycle = cycle;
                vld_log.push_back(din_data);
            end else begin
                wide_cnt++;
            end
        end
        if (frame_err) begin
            if (!prev_ferr) ferr_cnt++;
            else wide_cnt++;
        end
        if (din_vld && frame_err) both_cnt++;
        if (busy) busy_cnt++;
        prev_vld  = din_vld;
        prev_ferr = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_din = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cycle;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    initial begin
        int unsigned lat;

        // Reset values while held in reset.
        rst      = 1'b0;
        uart_din = 1'b1;
        tick(5);
        check("rst_vld",   32'(din_vld),   32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(din_data),  32'h00);
        rst = 1'b1;
        tick(20);
        check("idle_vld_cnt",  vld_cnt,         32'd0);
        check("idle_ferr_cnt", ferr_cnt,        32'd0);
        check("idle_busy",     32'(busy),       32'd0);
        check("idle_data",     32'(din_data),   32'h00);

        // Single byte 'a' with latency and busy coverage.
        busy_cnt = 0;
        send_frame(8'h61, 1'b1);
        tick(4);
        lat = vld_cycle - start_cyc;
        check("a_vld_cnt",   vld_cnt,                     32'd1);
        check("a_data_log",  32'(vld_log[0]),             32'h61);
        check("a_data_out",  32'(din_data),               32'h61);
        check("a_latency",   32'(lat >= 154 && lat <= 156), 32'd1);
        check("a_busy_len",  32'(busy_cnt >= 151 && busy_cnt <= 153), 32'd1);
        check("a_busy_end",  32'(busy),                   32'd0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h70, 1'b1);
        send_frame(8'h3B, 1'b1);
        tick(4);
        check("b2b_vld_cnt", vld_cnt,            32'd3);
        check("b2b_first",   32'(vld_log[1]),    32'h70);
        check("b2b_second",  32'(vld_log[2]),    32'h3B);
        check("b2b_ferr",    ferr_cnt,           32'd0);
        check("b2b_data",    32'(din_data),      32'h3B);

        // Short low glitch aborts in START.
        busy_cnt = 0;
        uart_din = 1'b0;
        tick(3);
        uart_din = 1'b1;
        tick(40);
        check("glitch_vld_cnt",   vld_cnt,               32'd3);
        check("glitch_ferr_cnt",  ferr_cnt,              32'd0);
        check("glitch_busy_seen", 32'(busy_cnt > 0),     32'd1);
        check("glitch_busy_end",  32'(busy),             32'd0);

        // Stop bit low then held low: one frame_err, parked in BREAK.
        send_frame(8'h6E, 1'b0);
        tick(30);
        check("brk_ferr_cnt", ferr_cnt,          32'd1);
        check("brk_vld_cnt",  vld_cnt,           32'd3);
        check("brk_data",     32'(din_data),     32'h3B);
        check("brk_busy",     32'(busy),         32'd1);
        tick(10);
        uart_din = 1'b1;
        tick(10);
        check("brk_exit_busy", 32'(busy),        32'd0);
        check("brk_ferr_once", ferr_cnt,         32'd1);

        // Reset asserted during data bit 4 of 8'h61.
        start_cyc = cycle;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h61 >> i) & 8'h01));
        uart_din = 1'b0;
        tick(8);
        rst      = 1'b0;
        uart_din = 1'b1;
        tick(3);
        check("mrst_data", 32'(din_data), 32'h00);
        check("mrst_busy", 32'(busy),     32'd0);
        check("mrst_vld",  32'(din_vld),  32'd0);
        rst = 1'b1;
        tick(30);
        check("mrst_vld_cnt",  vld_cnt,        32'd3);
        check("mrst_data_rel", 32'(din_data),  32'h00);
        send_frame(8'h3B, 1'b1);
        tick(4);
        check("post_vld_cnt",  vld_cnt,        32'd4);
        check("post_data_log", 32'(vld_log[3]), 32'h3B);
        check("post_data_out", 32'(din_data),  32'h3B);

        // Strobe shape over the whole run.
        check("strobe_width", wide_cnt, 32'd0);
        check("strobe_both",  both_cnt, 32'd0);
        check("ferr_total",   ferr_cnt, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
